// File: rtl/crtc_preset_loader.sv
// Programs the 6545 CRTC with a constant PET video preset (R0..NUM_REGS-1) as index/data
// write pairs, sharing the CRTC register bus with the CPU, which always has priority.
module crtc_preset_loader #(
    parameter int NUM_REGS = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       start,
    input  logic       preset_sel,
    input  logic       cpu_req,
    output logic       cpu_grant,
    output logic       bus_we,
    output logic       bus_rs,
    output logic [7:0] bus_d,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    // Bus slot handshake: ce marks one bus slot. The CPU claims a slot by raising cpu_req and
    // owns it whenever cpu_grant (= ce & cpu_req) is high. The loader may only use a ce slot
    // in which cpu_req=0. Its write then appears as a one-clk bus_we after that slot's edge,
    // with bus_rs/bus_d stable while bus_we=1.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_t     state, state_n;
    logic [3:0] idx, idx_n;
    logic       preset, preset_n;
    logic       we_n, rs_n;
    logic [7:0] d_n;

    // Preset 0 is the 40-column 4032 timing. Preset 1 is the 80-column 8032 timing.
    function automatic logic [7:0] rom_byte(input logic p, input logic [3:0] i);
        logic [7:0] v;
        case (i)
            4'd0:    v = 8'h31;
            4'd1:    v = 8'h28;
            4'd2:    v = 8'h29;
            4'd3:    v = 8'h0F;
            4'd4:    v = p ? 8'h20 : 8'h28;
            4'd5:    v = p ? 8'h03 : 8'h05;
            4'd6:    v = 8'h19;
            4'd7:    v = p ? 8'h1D : 8'h21;
            4'd8:    v = 8'h00;
            4'd9:    v = p ? 8'h09 : 8'h07;
            4'd12:   v = 8'h10;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign cpu_grant = ce & cpu_req;
    assign busy      = (state == S_ADDR) || (state == S_DATA);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        preset_n = preset;
        we_n     = 1'b0;
        rs_n     = bus_rs;
        d_n      = bus_d;
        case (state)
            S_IDLE: begin
                if (ce && start) begin
                    preset_n = preset_sel;
                    idx_n    = 4'd0;
                    state_n  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ce && !cpu_req) begin
                    we_n    = 1'b1;
                    rs_n    = 1'b0;
                    d_n     = {4'b0000, idx};
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (ce) begin
                    // A CPU slot here may have moved the CRTC index, so the index is re-sent.
                    if (cpu_req) begin
                        state_n = S_ADDR;
                    end else begin
                        we_n = 1'b1;
                        rs_n = 1'b1;
                        d_n  = rom_byte(preset, idx);
                        if (idx == LAST_IDX) begin
                            state_n = S_DONE;
                        end else begin
                            idx_n   = idx + 4'd1;
                            state_n = S_ADDR;
                        end
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= 4'd0;
            preset <= 1'b0;
            bus_we <= 1'b0;
            bus_rs <= 1'b0;
            bus_d  <= 8'h00;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            preset <= preset_n;
            bus_we <= we_n;
            bus_rs <= rs_n;
            bus_d  <= d_n;
        end
    end

endmodule

// File: tb/tb_crtc_preset_loader.sv
// Bench for crtc_preset_loader: a vector table, directed contention/reset sequences and
// random traffic, all checked against a queue-of-pending-writes reference model.
module tb_crtc_preset_loader;

  localparam int NUM_REGS = 14;

  logic       clk;
  logic       reset;
  logic       ce;
  logic       start;
  logic       preset_sel;
  logic       cpu_req;
  logic       cpu_grant;
  logic       bus_we;
  logic       bus_rs;
  logic [7:0] bus_d;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  crtc_preset_loader #(.NUM_REGS(NUM_REGS)) dut (
    .clk(clk),
    .reset(reset),
    .ce(ce),
    .start(start),
    .preset_sel(preset_sel),
    .cpu_req(cpu_req),
    .cpu_grant(cpu_grant),
    .bus_we(bus_we),
    .bus_rs(bus_rs),
    .bus_d(bus_d),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] p0_tab [16] = '{8'h31, 8'h28, 8'h29, 8'h0F, 8'h28, 8'h05, 8'h19, 8'h21,
                              8'h00, 8'h07, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
  logic [7:0] p1_tab [16] = '{8'h31, 8'h28, 8'h29, 8'h0F, 8'h20, 8'h03, 8'h19, 8'h1D,
                              8'h00, 8'h09, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};

  int n_tests = 0;
  int n_fail  = 0;

  // observed stream statistics
  int         n_we, n_done, cur_run, max_run;
  logic [8:0] wr_q[$];
  logic       g_last;

  // reference model: the register writes still owed, in order
  typedef struct packed {
    logic       rs;
    logic [7:0] d;
    logic [3:0] i;
  } wr_t;
  wr_t        m_q[$];
  bit         m_active = 0;
  bit         m_done = 0;
  logic       m_we = 1'b0;
  logic       m_rs = 1'b0;
  logic [7:0] m_d = 8'h00;

  function automatic logic [7:0] tab(input logic p, input int i);
    return p ? p1_tab[i] : p0_tab[i];
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic s, input logic p,
                            input logic q);
    bit  nd;
    wr_t w;
    nd   = 0;
    m_we = 1'b0;
    if (r) begin
      m_q.delete();
      m_active = 0;
      m_rs     = 1'b0;
      m_d      = 8'h00;
    end else if (m_active) begin
      if (c && q) begin
        if (m_q[0].rs) begin
          w.rs = 1'b0;
          w.i  = m_q[0].i;
          w.d  = {4'h0, m_q[0].i};
          m_q.push_front(w);
        end
      end else if (c) begin
        w    = m_q.pop_front();
        m_we = 1'b1;
        m_rs = w.rs;
        m_d  = w.d;
        if (m_q.size() == 0) begin
          m_active = 0;
          nd       = 1;
        end
      end
    end else if (!m_done && c && s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        w.i = 4'(i);
        w.rs = 1'b0;
        w.d = 8'(i);
        m_q.push_back(w);
        w.rs = 1'b1;
        w.d = tab(p, i);
        m_q.push_back(w);
      end
      m_active = 1;
    end
    m_done = nd;
  endtask

  // driver: one clock with the given inputs, checked against the model
  task automatic step(input logic r, input logic c, input logic s, input logic p, input logic q);
    reset = r;
    ce = c;
    start = s;
    preset_sel = p;
    cpu_req = q;
    #1;
    chk1("cpu_grant", cpu_grant, c & q);
    g_last = cpu_grant;
    @(posedge clk);
    model_edge(r, c, s, p, q);
    #1;
    chk1("bus_we", bus_we, m_we);
    chk1("bus_rs", bus_rs, m_rs);
    chk8("bus_d", bus_d, m_d);
    chk1("busy", busy, m_active);
    chk1("done", done, m_done);
    if (g_last) chk1("no_write_in_cpu_slot", bus_we, 1'b0);
    if (bus_we) begin
      n_we++;
      wr_q.push_back({bus_rs, bus_d});
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (done) n_done++;
  endtask

  // mode 0: plain, 1: CPU slot right after the R6 index write,
  // 2: CPU holds 10 slots after the R2 data write, 3: start held high, reset after R3 data
  task automatic run_seq(input logic sel, input int period, input int mode, output int slots);
    int   clk_n, req_left;
    bit   started, fin, trig, was;
    logic c, s, q, r;
    slots = 0; req_left = 0; clk_n = 0;
    started = 0; fin = 0; trig = 0;
    n_we = 0; n_done = 0; cur_run = 0; max_run = 0;
    wr_q.delete();
    while (!fin && clk_n < 4000) begin
      c = ((clk_n % period) == 0);
      s = (!started || mode == 3);
      r = (mode == 3 && trig);
      q = c && (req_left > 0);
      if (q) req_left--;
      was = started;
      step(r, c, s, sel, q);
      clk_n++;
      if (!was && busy) started = 1;
      if (c && started && !r) slots++;
      if (r || done) fin = 1;
      if (!trig && bus_we) begin
        if (mode == 1 && !bus_rs && bus_d == 8'h06) begin trig = 1; req_left = 1; end
        if (mode == 2 && bus_rs && bus_d == 8'h29) begin trig = 1; req_left = 10; end
        if (mode == 3 && bus_rs && bus_d == 8'h0F) trig = 1;
      end
    end
    chk1("seq_finished_in_budget", fin, 1'b1);
  endtask

  task automatic check_stream(input logic sel);
    chki("stream_len", wr_q.size(), 2 * NUM_REGS);
    if (wr_q.size() == 2 * NUM_REGS) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        chk8("stream_index", wr_q[2*i][7:0], 8'(i));
        chk1("stream_index_rs", wr_q[2*i][8], 1'b0);
        chk8("stream_data", wr_q[2*i+1][7:0], tab(sel, i));
        chk1("stream_data_rs", wr_q[2*i+1][8], 1'b1);
      end
    end
  endtask

  typedef struct {
    logic       r, c, s, p, q;
    logic       g, we, rs;
    logic [7:0] d;
    logic       busy, done;
  } vec_t;
  vec_t vecs[13];

  int slots;

  initial begin
    reset = 1'b1; ce = 1'b0; start = 1'b0; preset_sel = 1'b0; cpu_req = 1'b0;
    g_last = 1'b0;
    n_we = 0; n_done = 0; cur_run = 0; max_run = 0;

    //          r     c     s     p     q     grant we    rs    d      busy  done
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h31, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h28, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].r, vecs[i].c, vecs[i].s, vecs[i].p, vecs[i].q);
      chk1("vec_grant", g_last, vecs[i].g);
      chk1("vec_we", bus_we, vecs[i].we);
      chk1("vec_rs", bus_rs, vecs[i].rs);
      chk8("vec_d", bus_d, vecs[i].d);
      chk1("vec_busy", busy, vecs[i].busy);
      chk1("vec_done", done, vecs[i].done);
    end

    // preset 0, ce every clk, no contention
    run_seq(1'b0, 1, 0, slots);
    chki("p0_slots", slots, 29);
    chki("p0_writes", n_we, 28);
    chki("p0_done_count", n_done, 1);
    check_stream(1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("p0_idle_after_done", done | busy, 1'b0);

    // preset 1, ce every 4th clk
    run_seq(1'b1, 4, 0, slots);
    chki("p1_slots", slots, 29);
    chki("p1_we_width", max_run, 1);
    chki("p1_done_count", n_done, 1);
    check_stream(1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // CPU slot lands on the R6 data slot: index 06 is re-sent
    run_seq(1'b0, 1, 1, slots);
    chki("r6_slots", slots, 31);
    chki("r6_writes", n_we, 29);
    chk8("r6_index_first", 8'(wr_q[12]), {1'b0, 8'h06});
    chk8("r6_index_again", 8'(wr_q[13]), {1'b0, 8'h06});
    chk8("r6_data", 8'(wr_q[14]), 8'h19);
    chk1("r6_data_rs", wr_q[14][8], 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // CPU holds the bus for 10 slots while the loader waits in ADDR
    run_seq(1'b1, 1, 2, slots);
    chki("hold_slots", slots, 39);
    chki("hold_done_count", n_done, 1);
    check_stream(1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // start held high while busy, reset after the R3 data write
    run_seq(1'b0, 1, 3, slots);
    chki("rst_writes", n_we, 8);
    chki("rst_no_done", n_done, 0);
    chk1("rst_we", bus_we, 1'b0);
    chk1("rst_rs", bus_rs, 1'b0);
    chk8("rst_d", bus_d, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq(1'b0, 1, 0, slots);
    chki("rerun_slots", slots, 29);
    chki("rerun_done_count", n_done, 1);
    check_stream(1'b0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
